hamming_uart_tx_stream: RTL and testbench

Streaming successor to the single-shot Hamming-encode-then-transmit path. It accepts 4-bit nibbles over a valid/ready handshake and Hamming(7,4)-encodes each one on entry. Encoded codewords are buffered in a parametrised FIFO and sent gaplessly as UART frames with configurable bit period, optional parity and 1 or 2 stop bits. It sits between the user input pins and the tx output pin, replacing the edge-detect/one-frame-at-a-time glue.

---
 rtl/hamming_uart_tx_stream.sv | 164 ++++++++++++++++
 tb/tb_hamming_uart_tx_stream.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hamming_uart_tx_stream.sv
// Streams Hamming(7,4)-encoded nibbles through a codeword FIFO into a gapless UART transmitter.
module hamming_uart_tx_stream #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [3:0]                    in_data,
  output logic                          in_ready,
  input  logic                          clr_overflow,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      byte_q, byte_d;
  logic            tx_q, tx_d;
  logic [6:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q;
  logic            push, pop, bit_end, last_stop;
  logic [6:0]      code;

  assign in_ready  = (count_q != CW'(FIFO_DEPTH));
  assign push      = in_valid & in_ready;
  assign bit_end   = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign last_stop = (state_q == STOP) && bit_end && (bit_q == 3'(STOP_BITS - 1));

  always_comb begin
    code    = '0;
    code[6] = in_data[3];
    code[5] = in_data[2];
    code[4] = in_data[1];
    code[3] = in_data[1] ^ in_data[2] ^ in_data[3];
    code[2] = in_data[0];
    code[1] = in_data[0] ^ in_data[2] ^ in_data[3];
    code[0] = in_data[0] ^ in_data[1] ^ in_data[3];
  end

  // The frame following the last stop cycle is popped directly into START, so there is no idle gap.
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          byte_d  = {1'b0, mem_q[rd_q]};
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = byte_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = (^byte_q) ^ (PARITY_ODD != 0);
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = byte_q[bit_q + 3'd1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == 3'(STOP_BITS - 1)) begin
            if (count_q != '0) begin
              pop     = 1'b1;
              byte_d  = {1'b0, mem_q[rd_q]};
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      count_q <= count_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      if (in_valid && !in_ready) ovf_q <= 1'b1;
      else if (clr_overflow)     ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_q] <= code;
  end

  assign tx         = tx_q;
  assign tx_busy    = (state_q != IDLE);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign frame_done = last_stop;

endmodule

// File: tb/tb_hamming_uart_tx_stream.sv
module tb_hamming_uart_tx_stream;

  logic       clk = 1'b0;
  logic       rst, in_valid, clr;
  logic [3:0] in_data;
  logic [2:0] rdy, txw, busy, ovf, fd;
  logic [2:0] c0, c1;
  logic [1:0] c2;

  always #5 clk = ~clk;

  hamming_uart_tx_stream #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
    .clr_overflow(clr), .tx(txw[0]), .tx_busy(busy[0]), .fifo_count(c0),
    .overflow(ovf[0]), .frame_done(fd[0]));

  hamming_uart_tx_stream #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
    .clr_overflow(clr), .tx(txw[1]), .tx_busy(busy[1]), .fifo_count(c1),
    .overflow(ovf[1]), .frame_done(fd[1]));

  hamming_uart_tx_stream #(.CLKS_PER_BIT(3), .FIFO_DEPTH(2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[2]),
    .clr_overflow(clr), .tx(txw[2]), .tx_busy(busy[2]), .fifo_count(c2),
    .overflow(ovf[2]), .frame_done(fd[2]));

  int cpb   [3] = '{4, 4, 3};
  int depth [3] = '{4, 4, 2};
  int pen   [3] = '{0, 1, 1};
  int odd   [3] = '{0, 0, 1};
  int stops [3] = '{1, 1, 2};

  bit [6:0] mq [3][$];
  int       fpos [3];
  bit       fb [3][12];
  bit       mov [3];

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = ^(d & 4'b1011);
    p2 = ^(d & 4'b1101);
    p3 = ^(d & 4'b1110);
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  function automatic int flen(input int k);
    return 9 + pen[k] + stops[k];
  endfunction

  task automatic load_frame(input int k, input logic [6:0] cw);
    logic [7:0] b;
    b = {1'b0, cw};
    for (int i = 0; i < 12; i++) fb[k][i] = 1'b1;
    fb[k][0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[k][1 + i] = b[i];
    if (pen[k] != 0) fb[k][9] = (^b) ^ (odd[k] != 0);
  endtask

  task automatic model_step(input bit v, input logic [3:0] d, input bit c, input bit r);
    bit ready;
    int total;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        mq[k].delete();
        fpos[k] = -1;
        mov[k]  = 1'b0;
      end else begin
        ready = (mq[k].size() != depth[k]);
        total = flen(k) * cpb[k];
        if (fpos[k] < 0 || fpos[k] == total - 1) begin
          if (mq[k].size() > 0) begin
            load_frame(k, mq[k].pop_front());
            fpos[k] = 0;
          end else begin
            fpos[k] = -1;
          end
        end else begin
          fpos[k]++;
        end
        if (v && ready) mq[k].push_back(encode(d));
        if (v && !ready) mov[k] = 1'b1;
        else if (c)      mov[k] = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s[%0d] t=%0t got %0h want %0h", tag, k, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [7:0] cnt;
    for (int k = 0; k < 3; k++) begin
      cnt = (k == 0) ? {5'd0, c0} : (k == 1) ? {5'd0, c1} : {6'd0, c2};
      check("tx",         k, {7'd0, txw[k]},  {7'd0, (fpos[k] < 0) ? 1'b1 : fb[k][fpos[k] / cpb[k]]});
      check("tx_busy",    k, {7'd0, busy[k]}, {7'd0, fpos[k] >= 0});
      check("fifo_count", k, cnt,             8'(mq[k].size()));
      check("in_ready",   k, {7'd0, rdy[k]},  {7'd0, mq[k].size() != depth[k]});
      check("overflow",   k, {7'd0, ovf[k]},  {7'd0, mov[k]});
      check("frame_done", k, {7'd0, fd[k]},   {7'd0, fpos[k] == flen(k) * cpb[k] - 1});
    end
  endtask

  task automatic cyc(input bit v, input logic [3:0] d, input bit c, input bit r);
    in_valid = v;
    in_data  = d;
    clr      = c;
    rst      = r;
    @(posedge clk);
    model_step(v, d, c, r);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    int lat_fd, lat_busy;
    logic [3:0] burst [6];
    burst = '{4'h0, 4'h1, 4'hF, 4'hB, 4'h3, 4'h5};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clr = 1'b0;
    for (int k = 0; k < 3; k++) begin fpos[k] = -1; mov[k] = 1'b0; end

    // reset with in_valid held high
    cyc(1'b1, 4'($urandom), 1'b0, 1'b1);
    cyc(1'b1, 4'($urandom), 1'b0, 1'b1);
    idle(2);

    // single frame of 4'hB and its timing on the plain instance
    cyc(1'b1, 4'hB, 1'b0, 1'b0);
    lat_fd = -1; lat_busy = -1;
    for (int i = 1; i <= 60; i++) begin
      cyc(1'b0, 4'h0, 1'b0, 1'b0);
      if (fd[0] && lat_fd < 0) lat_fd = i;
      if (!busy[0] && lat_busy < 0) lat_busy = i;
    end
    check("frame_done_latency", 0, 8'(lat_fd), 8'd40);
    check("busy_fall_latency",  0, 8'(lat_busy), 8'd41);

    // burst with overflow, then clear
    for (int i = 0; i < 6; i++) cyc(1'b1, burst[i], 1'b0, 1'b0);
    check("burst_overflow", 0, {7'd0, ovf[0]}, 8'd1);
    idle(5);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    check("overflow_cleared", 0, {7'd0, ovf[0]}, 8'd0);
    idle(260);

    // back-to-back 4'hF, 4'h0 (two stop bits on u2), then 4'h1 for parity
    cyc(1'b1, 4'hF, 1'b0, 1'b0);
    cyc(1'b1, 4'h0, 1'b0, 1'b0);
    cyc(1'b1, 4'h1, 1'b0, 1'b0);
    idle(160);

    // reset during data bit 3 of u0 with two entries queued
    cyc(1'b1, 4'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 4'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 4'($urandom), 1'b0, 1'b0);
    idle(15);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    check("mid_reset_count", 0, {5'd0, c0}, 8'd0);
    idle(60);

    // randomized traffic, including overflow clears and occasional resets
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 15) == 0,
          $urandom_range(0, 299) == 0);
    idle(200);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
